// File: rtl/dcf77_pkg.sv
// DCF77 shared definitions: frame bit map, field widths, time bundle.
// Used by both the transmitter and the receiver.
package dcf77_pkg;

    localparam int FRAME_BITS = 59;
    localparam int CEST_BIT   = 17;
    localparam int CET_BIT    = 18;
    localparam int START_BIT  = 20;
    localparam int MIN_LSB    = 21;
    localparam int P1         = 28;
    localparam int HOUR_LSB   = 29;
    localparam int P2         = 35;
    localparam int DATE_LSB   = 36;
    localparam int P3         = 58;

    localparam int MIN_W  = 7;
    localparam int HOUR_W = 6;
    localparam int DAY_W  = 6;
    localparam int WDAY_W = 3;
    localparam int MON_W  = 5;
    localparam int YEAR_W = 8;
    localparam int DATE_W = DAY_W + WDAY_W + MON_W + YEAR_W;

    typedef struct packed {
        logic [MIN_W-1:0]  minute;
        logic [HOUR_W-1:0] hour;
        logic [DAY_W-1:0]  day;
        logic [WDAY_W-1:0] week_day;
        logic [MON_W-1:0]  month;
        logic [YEAR_W-1:0] year;
        logic              cest;
    } dcf77_time_t;

    // Lay out one minute frame; parity bits make each group even.
    function automatic logic [FRAME_BITS-1:0] dcf77_build(dcf77_time_t t);
        logic [FRAME_BITS-1:0] f;
        logic [DATE_W-1:0]     date;
        date = {t.year, t.month, t.week_day, t.day};
        f = '0;
        f[CEST_BIT]  = t.cest;
        f[CET_BIT]   = ~t.cest;
        f[START_BIT] = 1'b1;
        f[MIN_LSB +: MIN_W]   = t.minute;
        f[P1]                 = ^t.minute;
        f[HOUR_LSB +: HOUR_W] = t.hour;
        f[P2]                 = ^t.hour;
        f[DATE_LSB +: DATE_W] = date;
        f[P3]                 = ^date;
        return f;
    endfunction

endpackage

// File: rtl/dcf77_tick_gen.sv
// DCF77 timing chain: clock prescaler to 1 ms, ms counter, second index.
// Everything holds while enable is low.
module dcf77_tick_gen #(
    parameter int CLK_FREQ = 24000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    output logic [9:0] ms,
    output logic [5:0] second,
    output logic       sec_strobe,
    output logic       sec_end
);

    localparam int DIV = CLK_FREQ / 1000;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PW-1:0] pre;
    logic          ms_tick;

    assign ms_tick = enable && (pre == PW'(DIV - 1));
    assign sec_end = ms_tick && (ms == 10'd999);

    // Prescaler: one ms_tick every DIV enabled clocks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre <= '0;
        end else if (enable) begin
            pre <= ms_tick ? '0 : pre + PW'(1);
        end
    end

    // ms counter 0..999 and second index 59 -> 0 -> ... -> 59.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ms         <= '0;
            second     <= 6'd59;
            sec_strobe <= 1'b0;
        end else begin
            sec_strobe <= sec_end;
            if (ms_tick) begin
                ms <= sec_end ? 10'd0 : ms + 10'd1;
            end
            if (sec_end) begin
                second <= (second == 6'd59) ? 6'd0 : second + 6'd1;
            end
        end
    end

endmodule

// File: rtl/dcf77_tx.sv
// DCF77 time-code transmitter: shadow/frame registers and pulse generation.
// Frame is rebuilt from the shadow (or a coincident load) at each minute wrap.
module dcf77_tx
    import dcf77_pkg::*;
#(
    parameter int CLK_FREQ  = 24000000,
    parameter int PULSE0_MS = 100,
    parameter int PULSE1_MS = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       load,
    input  logic [6:0] minute,
    input  logic [5:0] hour,
    input  logic [5:0] day,
    input  logic [2:0] week_day,
    input  logic [4:0] month,
    input  logic [7:0] year,
    input  logic       cest,
    output logic       tx,
    output logic [5:0] second,
    output logic       sec_strobe,
    output logic       frame_req
);

    logic [9:0]            ms;
    logic                  sec_end;
    dcf77_time_t           shadow;
    dcf77_time_t           cur;
    logic [FRAME_BITS-1:0] frame;
    logic [9:0]            width;

    dcf77_tick_gen #(
        .CLK_FREQ(CLK_FREQ)
    ) u_tick (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .ms        (ms),
        .second    (second),
        .sec_strobe(sec_strobe),
        .sec_end   (sec_end)
    );

    // Shadow contents, bypassed by a load on the same cycle.
    always_comb begin
        cur = shadow;
        if (load) begin
            cur.minute   = minute;
            cur.hour     = hour;
            cur.day      = day;
            cur.week_day = week_day;
            cur.month    = month;
            cur.year     = year;
            cur.cest     = cest;
        end
    end

    // Pulse length for the bit of the current second.
    always_comb begin
        width = frame[second] ? 10'(PULSE1_MS) : 10'(PULSE0_MS);
    end

    // Shadow capture and frame latch at the 59 -> 0 wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow <= '0;
            frame  <= '0;
        end else begin
            shadow <= cur;
            if (sec_end && second == 6'd59) begin
                frame <= dcf77_build(cur);
            end
        end
    end

    // Registered pulse output and next-minute request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx        <= 1'b0;
            frame_req <= 1'b0;
        end else begin
            tx        <= enable && (second != 6'd59) && (ms < width);
            frame_req <= sec_end && (second == 6'd57);
        end
    end

endmodule

// File: tb/tb_dcf77_tx.sv
// Scoreboard bench for dcf77_tx at 1 clock per ms.
// Expected per-second pulse widths are queued at load time.
module tb_dcf77_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       load;
    logic [6:0] minute;
    logic [5:0] hour;
    logic [5:0] day;
    logic [2:0] week_day;
    logic [4:0] month;
    logic [7:0] year;
    logic       cest;
    logic       tx;
    logic [5:0] second;
    logic       sec_strobe;
    logic       frame_req;

    dcf77_tx #(
        .CLK_FREQ (1000),
        .PULSE0_MS(100),
        .PULSE1_MS(200)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .load      (load),
        .minute    (minute),
        .hour      (hour),
        .day       (day),
        .week_day  (week_day),
        .month     (month),
        .year      (year),
        .cest      (cest),
        .tx        (tx),
        .second    (second),
        .sec_strobe(sec_strobe),
        .frame_req (frame_req)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sec;
        int w;
    } exp_t;

    exp_t q[$];
    int   rise_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   hi = 0;
    int   cur_sec = 59;
    int   fr_cnt = 0;
    bit   mon_en = 0;
    logic tx_q = 1'b0;
    exp_t e_mon;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [58:0] model(
        input logic [6:0] mi, input logic [5:0] hr, input logic [5:0] dy,
        input logic [2:0] wd, input logic [4:0] mo, input logic [7:0] yr,
        input logic cs);
        logic [58:0] m;
        m = '0;
        m[17] = cs;
        m[18] = !cs;
        m[20] = 1'b1;
        for (int i = 0; i < 7; i++) m[21+i] = mi[i];
        m[28] = ^mi;
        for (int i = 0; i < 6; i++) m[29+i] = hr[i];
        m[35] = ^hr;
        for (int i = 0; i < 6; i++) m[36+i] = dy[i];
        for (int i = 0; i < 3; i++) m[42+i] = wd[i];
        for (int i = 0; i < 5; i++) m[45+i] = mo[i];
        for (int i = 0; i < 8; i++) m[50+i] = yr[i];
        m[58] = ^{dy, wd, mo, yr};
        return m;
    endfunction

    task automatic push_frame(input int nsec);
        logic [58:0] m;
        m = model(minute, hour, day, week_day, month, year, cest);
        for (int s = 0; s < nsec && s < 59; s++)
            q.push_back('{s, m[s] ? 200 : 100});
        if (nsec >= 60) q.push_back('{59, 0});
    endtask

    task automatic wait_sec(input int s, input int lim);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(sec_strobe && second == 6'(s)) && n < lim);
        if (n >= lim) check($sformatf("timeout_sec%0d", s), 0, 1);
    endtask

    always @(posedge clk) cyc++;

    // Monitor: per-second tx-high count compared against the queue.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sec_strobe) begin
                if (q.size() == 0) begin
                    check("sb_empty", 1, 0);
                end else begin
                    e_mon = q.pop_front();
                    check($sformatf("sec%0d_idx", e_mon.sec), cur_sec, e_mon.sec);
                    check($sformatf("sec%0d_width", e_mon.sec), hi, e_mon.w);
                end
                hi = int'(tx);
                cur_sec = int'(second);
            end else begin
                hi += int'(tx);
            end
            if (tx && !tx_q && second == 6'd0) rise_q.push_back(cyc);
            if (frame_req) begin
                fr_cnt++;
                check("frame_req_sec", int'(second), 58);
            end
        end
        tx_q = tx;
    end

    initial begin
        int n;
        int h;
        rst = 1'b0;
        enable = 1'b0;
        load = 1'b0;
        minute = '0;
        hour = '0;
        day = '0;
        week_day = '0;
        month = '0;
        year = '0;
        cest = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_tx", int'(tx), 0);
        check("rst_second", int'(second), 59);
        check("rst_strobe", int'(sec_strobe), 0);
        check("rst_frame_req", int'(frame_req), 0);

        // Release; first second is the 59 gap.
        rst = 1'b1;
        enable = 1'b1;
        q.push_back('{59, 0});
        cur_sec = 59;
        hi = 0;
        mon_en = 1;
        repeat (999) @(posedge clk);

        // Load coincident with the first 59 -> 0 edge.
        @(negedge clk);
        check("pre_wrap_second", int'(second), 59);
        load = 1'b1;
        minute = 7'h37;
        hour = 6'h12;
        day = 6'h24;
        week_day = 3'd3;
        month = 5'h08;
        year = 8'h25;
        cest = 1'b1;
        push_frame(60);
        @(negedge clk);
        load = 1'b0;
        check("wrap_second", int'(second), 0);
        check("wrap_strobe", int'(sec_strobe), 1);
        @(negedge clk);
        check("strobe_once", int'(sec_strobe), 0);

        // Mid-frame load: affects only the next frame.
        wait_sec(30, 40000);
        load = 1'b1;
        minute = 7'h38;
        push_frame(24);
        @(negedge clk);
        load = 1'b0;

        // Pause in the middle of the second-17 pulse of frame 2.
        wait_sec(0, 40000);
        wait_sec(17, 20000);
        repeat (50) @(negedge clk);
        check("en_pre_tx", int'(tx), 1);
        enable = 1'b0;
        @(negedge clk);
        check("en_off_tx", int'(tx), 0);
        repeat (20) @(negedge clk);
        check("en_hold_second", int'(second), 17);
        check("en_hold_tx", int'(tx), 0);
        enable = 1'b1;
        n = 0;
        h = 0;
        do begin
            @(negedge clk);
            n++;
            h += int'(tx);
        end while (!sec_strobe && n < 2000);
        check("resume_cycles", n, 950);
        check("resume_hi", h, 150);
        check("resume_second", int'(second), 18);

        wait_sec(24, 10000);
        @(negedge clk);
        mon_en = 0;
        check("sb_left", q.size(), 0);

        // Async reset during a 200 ms pulse.
        repeat (98) @(negedge clk);
        check("pulse_before_rst", int'(tx), 1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_tx", int'(tx), 0);
        check("async_rst_second", int'(second), 59);

        check("frame_req_count", fr_cnt, 1);
        check("rise_count", rise_q.size(), 2);
        if (rise_q.size() >= 2)
            check("rise_spacing", rise_q[1] - rise_q[0], 60000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
